// File: rtl/approx_add_arbiter.sv
// approx_add_arbiter
//   Two requesters compete for one approximate adder. A round-robin arbiter
//   grants one operand pair at a time. The granted sum is registered and
//   held in a single response slot until the consumer takes it. Counters
//   record how many responses each requester has completed.
//
//   Sum rule: the low APPROX_BITS positions are a|b and produce no carry.
//   The upper positions form an exact ripple sum with carry-in 0. The MSB of
//   rsp_sum is the carry-out of that exact slice.
//
//   Optional feature (macro APPROX_ADD_EXACT_BYPASS_EN):
//   adds req0_exact/req1_exact inputs. A request accepted with exact=1 uses
//   the exact ripple sum across all WIDTH bits.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   reqN_valid, reqN_ready   request handshake for requester N (0/1)
//   reqN_a, reqN_b           operands for requester N
//   reqN_exact               exact-sum request for requester N (bypass build only)
//   rsp_valid, rsp_ready     response handshake
//   rsp_sum                  WIDTH+1 bit result (carry-out in the MSB)
//   rsp_id                   requester that owns rsp_sum
//   cnt0, cnt1               saturating completed-response counters
module approx_add_arbiter #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
`ifdef APPROX_ADD_EXACT_BYPASS_EN
  input  logic             req0_exact,
  input  logic             req1_exact,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH:0]   rsp_sum,
  output logic             rsp_id,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
);

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  state_t state, state_nxt;
  logic   last_grant;   // requester granted most recently
  logic   grant_id;     // requester that would win this cycle
  logic   any_valid;
  logic   can_accept;
  logic   accept;
  logic   retire;
  logic   sel_exact;
  logic [WIDTH-1:0] sel_a, sel_b;

  // Bit-serial description of the sum rule. Positions below APPROX_BITS are
  // OR-ed and never produce a carry. All other positions ripple. When exact
  // is set, every position ripples.
  function automatic logic [WIDTH:0] calc_sum(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             exact);
    logic           carry;
    logic [WIDTH:0] s;
    // NOTE: blocking assignments are correct inside functions/always_comb;
    // the carry must update in order from bit to bit within one evaluation.
    carry = 1'b0;
    s     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!exact && (i < APPROX_BITS)) begin
        s[i] = a[i] | b[i];
      end else begin
        s[i]  = a[i] ^ b[i] ^ carry;
        carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
    end
    s[WIDTH] = carry;
    return s;
  endfunction

  // Arbitration looks only at the valids and the pointer. It never looks at
  // the operands, so the readies cannot depend on operand values.
  // Under contention the requester not granted last wins. A sole requester
  // always wins.
  assign any_valid  = req0_valid | req1_valid;
  assign grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  // The slot is free when empty or when it is being drained this cycle.
  assign can_accept = !rst && ((state == IDLE) || rsp_ready);
  assign accept     = can_accept && any_valid;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept &&  grant_id;
  assign retire     = (state == FULL) && rsp_ready;
  assign rsp_valid  = (state == FULL);

  assign sel_a = grant_id ? req1_a : req0_a;
  assign sel_b = grant_id ? req1_b : req0_b;
`ifdef APPROX_ADD_EXACT_BYPASS_EN
  assign sel_exact = grant_id ? req1_exact : req0_exact;
`else
  assign sel_exact = 1'b0;
`endif

  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt (no latch).
    state_nxt = state;
    if (accept) begin
      state_nxt = FULL;
    end else if (retire) begin
      state_nxt = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      rsp_sum    <= '0;
      rsp_id     <= 1'b0;
      cnt0       <= '0;
      cnt1       <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rsp_sum    <= calc_sum(sel_a, sel_b, sel_exact);
        rsp_id     <= grant_id;
        last_grant <= grant_id;
      end
      if (retire) begin
        if (!rsp_id && (cnt0 != 16'hFFFF)) cnt0 <= cnt0 + 16'd1;
        if ( rsp_id && (cnt1 != 16'hFFFF)) cnt1 <= cnt1 + 16'd1;
      end
    end
  end

endmodule
